// File: rtl/game_pkg.sv
// game_pkg: draw-engine state encoding and default geometry shared by the game blocks.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_PAINT,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    localparam int DEF_SIZE     = 4;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    // A counter for n values needs at least one bit, even when n is 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_scanner.sv
// pixel_scanner: row-major cx/cy counter over a SIZE x SIZE square.
module pixel_scanner
    import game_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int CW   = cnt_w(DEF_SIZE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] cx_d,
    output logic [CW-1:0] cy_d,
    output logic          last
);

    localparam logic [CW-1:0] MAX = CW'(SIZE - 1);

    logic [CW-1:0] cx_q;
    logic [CW-1:0] cy_q;

    // Next counts are exported so the owner can register pixel outputs in step with them.
    always_comb begin
        last = (cx_q == MAX) && (cy_q == MAX);
        cx_d = clear ? '0 : enable ? ((cx_q == MAX) ? '0 : cx_q + 1'b1) : cx_q;
        cy_d = clear ? '0 : (enable && cx_q == MAX) ? ((cy_q == MAX) ? '0 : cy_q + 1'b1) : cy_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/square_drawer.sv
// square_drawer: erases a square at its old position, paints it at the new one,
// then pulses finish_drawing; drives the VGA adapter pixel interface.
module square_drawer
    import game_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                draw,
    input  logic                erase_en,
    input  logic [X_W-1:0]      old_x,
    input  logic [Y_W-1:0]      old_y,
    input  logic [X_W-1:0]      new_x,
    input  logic [Y_W-1:0]      new_y,
    input  logic [COLOUR_W-1:0] fg_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                finish_drawing
);

    localparam int CW = cnt_w(SIZE);
    localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);

    state_t state_q, state_d;
    logic [X_W-1:0]      ox_q, ox_d, nx_q, nx_d;
    logic [Y_W-1:0]      oy_q, oy_d, ny_q, ny_d;
    logic [COLOUR_W-1:0] fg_q, fg_d, bg_q, bg_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                fin_q, fin_d;

    logic          clear, enable, last;
    logic [CW-1:0] cx_d, cy_d;
    logic          active, erasing;
    logic [X_W:0]  sx;
    logic [Y_W:0]  sy;

    pixel_scanner #(
        .SIZE(SIZE),
        .CW  (CW)
    ) u_scan (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .enable(enable),
        .cx_d  (cx_d),
        .cy_d  (cy_d),
        .last  (last)
    );

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        enable  = 1'b0;
        ox_d    = ox_q;
        oy_d    = oy_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        case (state_q)
            S_IDLE: begin
                clear = 1'b1;
                if (draw) begin
                    ox_d    = old_x;
                    oy_d    = old_y;
                    nx_d    = new_x;
                    ny_d    = new_y;
                    fg_d    = fg_colour;
                    bg_d    = bg_colour;
                    state_d = erase_en ? S_ERASE : S_PAINT;
                end
            end
            S_ERASE: begin
                clear   = !draw || last;
                enable  = draw && !last;
                state_d = !draw ? S_IDLE : last ? S_PAINT : S_ERASE;
            end
            S_PAINT: begin
                clear   = !draw || last;
                enable  = draw && !last;
                state_d = !draw ? S_IDLE : last ? S_DONE : S_PAINT;
            end
            S_DONE:     state_d = draw ? S_WAIT_LOW : S_IDLE;
            S_WAIT_LOW: state_d = draw ? S_WAIT_LOW : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state and next counts so each cycle shows its own pixel.
    always_comb begin
        erasing  = (state_d == S_ERASE);
        active   = erasing || (state_d == S_PAINT);
        sx       = {1'b0, erasing ? ox_d : nx_d} + (X_W + 1)'(cx_d);
        sy       = {1'b0, erasing ? oy_d : ny_d} + (Y_W + 1)'(cy_d);
        x_d      = active ? sx[X_W-1:0] : '0;
        y_d      = active ? sy[Y_W-1:0] : '0;
        colour_d = active ? (erasing ? bg_d : fg_d) : '0;
        plot_d   = active && (sx < X_LIM) && (sy < Y_LIM);
        fin_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ox_q     <= '0;
            oy_q     <= '0;
            nx_q     <= '0;
            ny_q     <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            fin_q    <= fin_d;
        end
    end

    assign x              = x_q;
    assign y              = y_q;
    assign colour         = colour_q;
    assign plot           = plot_q;
    assign finish_drawing = fin_q;

endmodule

// File: tb/tb_square_drawer.sv
// tb_square_drawer: directed frames for square_drawer, checked cycle by cycle
// against expected pixels derived from the frame arguments.
module tb_square_drawer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       draw = 1'b0;
    logic       erase_en = 1'b0;
    logic [7:0] old_x = '0, new_x = '0, x;
    logic [6:0] old_y = '0, new_y = '0, y;
    logic [2:0] fg_colour = '0, bg_colour = '0, colour;
    logic       plot, finish_drawing;

    int n_cmp = 0;
    int n_err = 0;

    square_drawer dut (
        .clock         (clock),
        .reset         (reset),
        .draw          (draw),
        .erase_en      (erase_en),
        .old_x         (old_x),
        .old_y         (old_y),
        .new_x         (new_x),
        .new_y         (new_y),
        .fg_colour     (fg_colour),
        .bg_colour     (bg_colour),
        .x             (x),
        .y             (y),
        .colour        (colour),
        .plot          (plot),
        .finish_drawing(finish_drawing)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".plot"}, 32'(plot), 0);
        chk({tag, ".fin"}, 32'(finish_drawing), 0);
        chk({tag, ".x"}, 32'(x), 0);
        chk({tag, ".y"}, 32'(y), 0);
        chk({tag, ".colour"}, 32'(colour), 0);
    endtask

    // One complete frame; inputs are scrambled mid-pass to show only latched copies matter.
    task automatic frame(input bit er, input int ox, input int oy, input int nx, input int ny,
                         input int fg, input int bg, input bit hold, input string tag);
        int total, idx, bx, by, px, py, col, pix;
        @(negedge clock);
        erase_en  = er;
        old_x     = 8'(ox);
        old_y     = 7'(oy);
        new_x     = 8'(nx);
        new_y     = 7'(ny);
        fg_colour = 3'(fg);
        bg_colour = 3'(bg);
        draw      = 1'b1;
        total     = er ? 33 : 17;
        pix       = 0;
        for (int k = 1; k <= total; k++) begin
            @(negedge clock);
            if (k < total) begin
                idx = (er && k > 16) ? k - 17 : k - 1;
                bx  = (er && k <= 16) ? ox : nx;
                by  = (er && k <= 16) ? oy : ny;
                col = (er && k <= 16) ? bg : fg;
                px  = bx + idx % 4;
                py  = by + idx / 4;
                chk({tag, ".x"}, 32'(x), 32'(px % 256));
                chk({tag, ".y"}, 32'(y), 32'(py % 128));
                chk({tag, ".colour"}, 32'(colour), 32'(col));
                chk({tag, ".plot"}, 32'(plot), 32'(px < 160 && py < 120));
                chk({tag, ".fin_low"}, 32'(finish_drawing), 0);
                pix += int'(plot);
            end else begin
                chk({tag, ".fin_pulse"}, 32'(finish_drawing), 1);
                chk({tag, ".done_plot"}, 32'(plot), 0);
                if (!hold) draw = 1'b0;
            end
            if (k == 3) begin
                old_x     = ~old_x;
                new_x     = ~new_x;
                new_y     = ~new_y;
                fg_colour = ~fg_colour;
                bg_colour = ~bg_colour;
                erase_en  = ~erase_en;
            end
        end
        if (hold) begin
            repeat (3) begin
                @(negedge clock);
                chk_quiet({tag, ".stale"});
            end
            draw = 1'b0;
        end
        @(negedge clock);
        chk_quiet({tag, ".after"});
        if (er && nx >= 158) chk({tag, ".npix"}, 32'(pix), 32'(16 + 4));
    endtask

    initial begin
        int cnt;
        #1 chk_quiet("reset");
        #20 reset = 1'b1;

        frame(1, 10, 20, 11, 20, 4, 0, 0, "basic");
        frame(0, 30, 30, 0, 0, 5, 2, 0, "noerase");
        frame(0, 0, 0, 158, 118, 7, 1, 0, "clip");
        frame(1, 5, 5, 158, 118, 6, 3, 0, "clip_er");

        // Abort after five erase pixels, then restart from the first pixel.
        @(negedge clock);
        erase_en = 1'b1; old_x = 8'd40; old_y = 7'd50; new_x = 8'd41; new_y = 7'd50;
        fg_colour = 3'd2; bg_colour = 3'd1; draw = 1'b1;
        repeat (5) @(negedge clock);
        chk("abort.x5", 32'(x), 32'd40);
        chk("abort.y5", 32'(y), 32'd51);
        chk("abort.plot5", 32'(plot), 1);
        draw = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            cnt += int'(plot) + int'(finish_drawing);
        end
        chk("abort.quiet", 32'(cnt), 0);
        chk_quiet("abort.idle");
        frame(1, 40, 50, 41, 50, 2, 1, 0, "restart");

        // Asynchronous reset between edges in the middle of a paint pass.
        @(negedge clock);
        erase_en = 1'b0; new_x = 8'd50; new_y = 7'd60; fg_colour = 3'd7; draw = 1'b1;
        repeat (6) @(negedge clock);
        chk("rst.pre_plot", 32'(plot), 1);
        #2 reset = 1'b0;
        #1 chk_quiet("rst.now");
        draw = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clock);
            cnt += int'(plot) + int'(finish_drawing);
        end
        chk("rst.idle", 32'(cnt), 0);

        frame(1, 60, 70, 61, 71, 3, 0, 1, "stale");
        frame(0, 0, 0, 1, 2, 1, 0, 0, "after_stale");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/square_drawer.md
# square_drawer

Pixel-sweep draw engine that answers the game controller's `draw` request. On each request it erases the square at its previous position with the background colour, paints it at its new position, then pulses `finish_drawing` so the controller can leave its draw state. It sits between the game controller and the VGA adapter and drives the adapter's `x`, `y`, `colour` and `plot` inputs.

## Interface
- `SIZE`, 4: square side in pixels; must be ≥ 1.
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `COLOUR_W`, 3: colour width.
- `SCREEN_W`, 160: visible width; pixels with x ≥ `SCREEN_W` are not plotted.
- `SCREEN_H`, 120: visible height; pixels with y ≥ `SCREEN_H` are not plotted.

Ports:
- `clock` in 1: system clock, all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `draw` in 1: level request from the controller, held high until `finish_drawing` is seen.
- `erase_en` in 1: when 1, erase the old position first; when 0, skip the erase pass (first frame).
- `old_x` in `X_W`, `old_y` in `Y_W`: previous top-left corner.
- `new_x` in `X_W`, `new_y` in `Y_W`: new top-left corner.
- `fg_colour` in `COLOUR_W`: square colour.
- `bg_colour` in `COLOUR_W`: background colour.
- `x` out `X_W`, `y` out `Y_W`, `colour` out `COLOUR_W`: current pixel, registered.
- `plot` out 1: registered write strobe for the current pixel.
- `finish_drawing` out 1: registered, one-cycle completion pulse.

## Operation
- States: `S_IDLE`, `S_ERASE`, `S_PAINT`, `S_DONE`, `S_WAIT_LOW`.
- **`S_IDLE`:**
  - If `draw` = 1 at an edge, latch `old_*`, `new_*`, both colours and `erase_en`. Clear the scan counters `cx` and `cy`.
  - Go to `S_ERASE` if the latched `erase_en` = 1, else to `S_PAINT`.
- **Scan order:** row-major. `cx` counts 0..SIZE-1 fastest, then `cy` increments. A pass is exactly SIZE² cycles, one pixel per cycle.
- **`S_ERASE`:** pixel (`old_x`+`cx`, `old_y`+`cy`) with `bg_colour`. After the last pixel, clear the counters and go to `S_PAINT`.
- **`S_PAINT`:** pixel (`new_x`+`cx`, `new_y`+`cy`) with `fg_colour`. After the last pixel, go to `S_DONE`.
- **`S_DONE`:** `finish_drawing` = 1 and `plot` = 0 for one cycle. Go to `S_IDLE` if `draw` = 0, else to `S_WAIT_LOW`.
- **`S_WAIT_LOW`:** hold all outputs at 0 until `draw` = 0, then go to `S_IDLE`. This prevents a retrigger from a stale request.
- **Arithmetic:** coordinate sums are computed one bit wider than the port.
  - `plot` = 1 only if the wide sum is below `SCREEN_W` / `SCREEN_H`.
  - Clipped pixels still consume their cycle.
  - `x` and `y` carry the truncated sum.
- **Abort:** `draw` falling during `S_ERASE` or `S_PAINT` sends the block to `S_IDLE` on the next edge. No `finish_drawing` pulse is produced and `plot` is 0 from that edge on.
- **Input changes mid-pass:** changes to coordinate or colour inputs have no effect; only the latched copies are used.

## Timing
- **Reset:** `reset` = 0 immediately forces `S_IDLE`, clears `cx` and `cy`, and sets `x`, `y`, `colour`, `plot` and `finish_drawing` to 0. This holds mid-pass too; no further pixels are emitted.
- **Latency:** if `draw` is sampled at edge E0, the first pixel is valid in the cycle after E0.
- **With erase:** `finish_drawing` is high in cycle 2·SIZE² + 1 after E0. For SIZE = 4 that is cycle 33.
- **Without erase:** `finish_drawing` is high in cycle SIZE² + 1 after E0. For SIZE = 4 that is cycle 17.
- **Handshake:** the controller sees `finish_drawing` combinationally and drops `draw` on the next edge. The drawer is then in `S_IDLE` with `draw` = 0, so back-to-back frames need no idle gap beyond the controller's own states.
- **`plot` = 1 cycles:** exactly the ERASE and PAINT cycles with in-screen pixels.

## Structure
- **Shared package `game_pkg`:** state encoding for `S_*`, default `SIZE`, `SCREEN_W`, `SCREEN_H`, `X_W`, `Y_W`, `COLOUR_W`, shared with the controller and the position-update block.
- **Sub-module `pixel_scanner`:**
  - Holds the `cx`/`cy` counter with `clear` and `enable` inputs and a `last` output, which is high when `cx` = `cy` = SIZE-1.
  - Is instantiated once and reused for both passes.

## Test plan
- **Basic frame:** SIZE = 4, `erase_en` = 1, old (10,20), new (11,20), fg 3'b100, bg 3'b000, `draw` held.
  - 16 plots at x 10–13 / y 20–23 in colour 0, then 16 plots at x 11–14 / y 20–23 in colour 4.
  - `finish_drawing` high for exactly one cycle, at cycle 33.
- **Skip erase:** `erase_en` = 0, new (0,0).
  - 16 plots at (0..3, 0..3), `finish_drawing` at cycle 17, no bg pixels.
- **Clipping:** new (158,118), `erase_en` = 0.
  - 16 scan cycles; `plot` = 1 only for x in {158,159} and y in {118,119}, i.e. 4 pixels.
  - `finish_drawing` still at cycle 17.
- **Abort:** drop `draw` after 5 ERASE pixels.
  - `plot` = 0 from the next edge, no `finish_drawing`.
  - Back in `S_IDLE`; a new `draw` restarts from `cx` = `cy` = 0.
- **Reset mid-paint:** assert `reset` = 0 asynchronously between edges.
  - All outputs 0 immediately.
  - After release with `draw` = 0, the block stays idle.
- **Stale request:** hold `draw` high for 3 cycles past `finish_drawing`.
  - Exactly one `finish_drawing` pulse and no new pixels until `draw` goes low, then high again.
